udc_step_ctrl: RTL and testbench
================================

# udc_step_ctrl

Controller for the 4-bit up/down counter and 7-segment display path. It arbitrates two push-button requesters (count-up, count-down) and converts accepted presses into single-cycle step pulses with a registered direction. It applies saturate or wrap limits using a shadow count, and optionally auto-repeats while a button is held. It sits between the synchronized button inputs and the counter's `up` and enable controls.

## Interface
- `PRESCALE`, 4 — clk cycles per timing tick; must be ≥1.
- `REPEAT_DLY`, 3 — ticks from the first step to the first auto-repeat step; must be ≥1.
- `REPEAT_RATE`, 1 — ticks between later auto-repeat steps; must be ≥1.

- `clk`  in  1  — sole clock, rising edge.
- `reset`  in  1  — synchronous, active-high.
- `btn_up`  in  1  — count-up request, level, already synchronized to `clk`.
- `btn_dn`  in  1  — count-down request, level, already synchronized to `clk`.
- `mode_wrap`  in  1  — 1: wrap at 15↔0; 0: saturate at 15 and 0.
- `up`  out  1  — direction to the counter; valid when `step`=1 and held until the next step.
- `step`  out  1  — one-cycle counter enable.
- `count`  out  4  — shadow of the counter value.
- `busy`  out  1  — 1 in any state other than IDLE.

## Operation
- Edge detect uses registered previous samples `prev_up` and `prev_dn`. A press is `btn_x`=1 with `prev_x`=0, evaluated only in IDLE.
- Arbitration, in IDLE:
  - Single press: grant that direction.
  - Both presses in the same cycle: round-robin. Grant the opposite of the last granted direction.
  - `last_grant` resets to down, so the first tie grants up.
- FSM states: IDLE, FIRE, HOLD, REPEAT.
  - IDLE → FIRE on a granted press. `up` is loaded with the granted direction and the prescaler is cleared.
  - FIRE (one cycle): assert `step` unless limited (see limits). Then go to REPEAT if the macro is defined, else HOLD.
  - HOLD: no steps. When the granted button reads 0, go to IDLE.
  - REPEAT: count ticks. After REPEAT_DLY ticks, step, then step every REPEAT_RATE ticks. When the granted button reads 0, go to IDLE with no further step. A release has priority over a tick falling in the same cycle.
- The non-granted button is ignored until return to IDLE. If it is still held then, it is not a new edge and needs release and re-press.
- Limits:
  - `mode_wrap`=0: a step that would go up from 15 or down from 0 is suppressed (`step` stays 0, `count` holds). The FSM still sequences normally.
  - `mode_wrap`=1: 15+1→0 and 0−1→15, mod 16.
  - `mode_wrap` is sampled at each step cycle.
- `count` updates on the clock edge that ends the `step` cycle.

## Timing
- Reset values:
  - `step`=0, `up`=0, `count`=0, `busy`=0, state IDLE, prescaler 0, `last_grant`=down.
  - `prev_up`=`prev_dn`=1, so a button held through reset causes no press.
- Reset mid-operation: next cycle is IDLE with all outputs at reset values. A pending repeat is discarded.
- Latency: the press is sampled at edge N. `step`=1 in the cycle after edge N+1; `count` is new after edge N+2.
- Ticks: the prescaler counts 0..PRESCALE−1 from the FIRE cycle. A tick is the terminal count.
- First repeat step occurs REPEAT_DLY·PRESCALE cycles after the FIRE step, then every REPEAT_RATE·PRESCALE cycles.
- `step` is never high on two consecutive cycles unless PRESCALE·REPEAT_RATE=1.
- `busy` rises with FIRE and falls in the cycle IDLE is re-entered.

## Configuration
- `UDC_STEP_CTRL_AUTOREPEAT_EN`
  - Defined: REPEAT state and its tick counter are compiled in; a held button auto-repeats.
  - Undefined: FIRE → HOLD; exactly one step per press; REPEAT logic is absent and the REPEAT_* parameters are unused.

## Test plan
- Reset, then pulse `btn_up` for 3 cycles, three times (`mode_wrap`=1) → three single-cycle `step` with `up`=1; `count`=3; `busy` low between presses.
- `count`=15, `mode_wrap`=0, press `btn_up` → no `step`, `count` stays 15; with `mode_wrap`=1 → `step`, `count`=0. Same check for down at 0 (→0 saturate, →15 wrap).
- `btn_up` and `btn_dn` rise in the same cycle, twice after reset (with release between) → first grant up, second grant down.
- With the macro defined, defaults, hold `btn_dn` from `count`=10 for 30 cycles → steps at FIRE, +12, +16, +20, +24, +28 cycles; `count`=4; no step after release.
- Macro undefined, hold `btn_up` 40 cycles → exactly one step; `btn_dn` pressed during the hold is ignored.
- Assert `reset` for 1 cycle during REPEAT while `btn_up` is held → outputs return to reset values; no step until `btn_up` is released and re-pressed.

Source files
------------

// File: rtl/udc_step_ctrl_if.sv
// Button/step bundle between the synchronized push-buttons, udc_step_ctrl and the
// 4-bit counter. The master drives the buttons and mode; the slave drives the controls.
interface udc_step_ctrl_if;
  logic       btn_up;
  logic       btn_dn;
  logic       mode_wrap;
  logic       up;
  logic       step;
  logic [3:0] count;
  logic       busy;

  modport master (output btn_up, btn_dn, mode_wrap, input up, step, count, busy);
  modport slave  (input btn_up, btn_dn, mode_wrap, output up, step, count, busy);
endinterface

// File: rtl/udc_step_ctrl.sv
// Up/down step controller: arbitrates the two buttons, emits one-cycle steps with a
// registered direction, and keeps a shadow count. Define UDC_STEP_CTRL_AUTOREPEAT_EN for auto-repeat.
module udc_step_ctrl #(
  parameter int PRESCALE    = 4,
  parameter int REPEAT_DLY  = 3,
  parameter int REPEAT_RATE = 1
) (
  input  logic           clk,
  input  logic           reset,
  udc_step_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FIRE, HOLD, REPEAT} state_t;

  state_t     state, state_n;
  logic       prev_up, prev_dn;
  logic       last_grant, last_grant_n;
  logic       up_q, up_n;
  logic       step_q, step_n;
  logic [3:0] count_q, cnt_eff;
  logic       press_up, press_dn, held, sat, rpt_due;

  assign press_up = bus.btn_up & ~prev_up;
  assign press_dn = bus.btn_dn & ~prev_dn;
  assign held     = up_q ? bus.btn_up : bus.btn_dn;

  // Count including the step on the wire now, so back-to-back steps see the right limit.
  assign cnt_eff = step_q ? (up_q ? count_q + 4'd1 : count_q - 4'd1) : count_q;
  assign sat     = ~bus.mode_wrap & (up_q ? (cnt_eff == 4'hF) : (cnt_eff == 4'h0));

`ifdef UDC_STEP_CTRL_AUTOREPEAT_EN
  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic [PW-1:0] pre_q;
  logic [TW-1:0] tcnt_q, tcnt_end;
  logic          first_q, tick;

  assign tick     = (pre_q == PW'(PRESCALE - 1));
  assign tcnt_end = first_q ? TW'(REPEAT_DLY - 1) : TW'(REPEAT_RATE - 1);
  assign rpt_due  = tick & (tcnt_q == tcnt_end);

  // Prescaler sits at 0 through FIRE and starts counting on the first REPEAT cycle.
  always_ff @(posedge clk) begin
    if (reset || state != REPEAT) begin
      pre_q   <= '0;
      tcnt_q  <= '0;
      first_q <= 1'b1;
    end else if (tick) begin
      pre_q <= '0;
      if (rpt_due) begin
        tcnt_q  <= '0;
        first_q <= 1'b0;
      end else begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end
`else
  localparam int unused_cfg = PRESCALE + REPEAT_DLY + REPEAT_RATE;
  assign rpt_due = 1'b0;
`endif

  always_comb begin
    state_n      = state;
    up_n         = up_q;
    last_grant_n = last_grant;
    step_n       = 1'b0;
    case (state)
      IDLE: begin
        if (press_up | press_dn) begin
          up_n         = (press_up & press_dn) ? ~last_grant : press_up;
          last_grant_n = up_n;
          state_n      = FIRE;
        end
      end
      FIRE: begin
        step_n = ~sat;
`ifdef UDC_STEP_CTRL_AUTOREPEAT_EN
        state_n = REPEAT;
`else
        state_n = HOLD;
`endif
      end
      HOLD: begin
        if (!held) state_n = IDLE;
      end
      REPEAT: begin
        // Release wins over a tick landing in the same cycle.
        if (!held) state_n = IDLE;
        else       step_n  = rpt_due & ~sat;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prev_up    <= 1'b1;
      prev_dn    <= 1'b1;
      last_grant <= 1'b0;
      up_q       <= 1'b0;
      step_q     <= 1'b0;
      count_q    <= 4'h0;
    end else begin
      state      <= state_n;
      prev_up    <= bus.btn_up;
      prev_dn    <= bus.btn_dn;
      last_grant <= last_grant_n;
      up_q       <= up_n;
      step_q     <= step_n;
      count_q    <= cnt_eff;
    end
  end

  assign bus.up    = up_q;
  assign bus.step  = step_q;
  assign bus.count = count_q;
  assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_udc_step_ctrl.sv
// Bench for udc_step_ctrl: a press/age model checked every cycle, plus literal
// expectations on counts, directions and repeat spacing.
module tb_udc_step_ctrl;
  localparam int P = 4;
  localparam int D = 3;
  localparam int R = 1;
`ifdef UDC_STEP_CTRL_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  udc_step_ctrl_if bus();

  udc_step_ctrl #(.PRESCALE(P), .REPEAT_DLY(D), .REPEAT_RATE(R)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_steps = 0;
  int ncyc = 0;
  int stimes[$];
  logic last_dir = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a press opens a busy window; FIRE is age 0, repeats fall at fixed ages.
  logic       m_busy, m_up, m_step, m_last, m_pu, m_pd, m_live;
  logic [3:0] m_count, m_c;
  logic       m_held, m_press_u, m_press_d, m_ns;
  int         m_age;

  initial m_live = 1'b0;

  function automatic logic may_step(input logic dir, input logic [3:0] c, input logic wrap);
    return wrap || (dir ? (c != 4'd15) : (c != 4'd0));
  endfunction

  always @(posedge clk) begin
    m_ns = 1'b0;
    if (reset) begin
      m_busy = 1'b0; m_up = 1'b0; m_last = 1'b0; m_count = 4'd0;
      m_pu = 1'b1; m_pd = 1'b1; m_age = 0; m_live = 1'b1;
    end else begin
      m_c       = m_count + (m_step ? (m_up ? 4'd1 : 4'd15) : 4'd0);
      m_press_u = bus.btn_up & ~m_pu;
      m_press_d = bus.btn_dn & ~m_pd;
      m_held    = m_up ? bus.btn_up : bus.btn_dn;
      if (!m_busy) begin
        if (m_press_u | m_press_d) begin
          m_up   = (m_press_u & m_press_d) ? ~m_last : m_press_u;
          m_last = m_up;
          m_busy = 1'b1;
          m_age  = 0;
        end
      end else if (m_age == 0) begin
        m_ns  = may_step(m_up, m_c, bus.mode_wrap);
        m_age = 1;
      end else if (!m_held) begin
        m_busy = 1'b0;
      end else begin
        if (AR && m_age >= P*D && ((m_age - P*D) % (P*R)) == 0)
          m_ns = may_step(m_up, m_c, bus.mode_wrap);
        m_age++;
      end
      m_pu = bus.btn_up;
      m_pd = bus.btn_dn;
      m_count = m_c;
    end
    m_step = m_ns;
  end

  always @(negedge clk) begin
    if (m_live) begin
      ncyc++;
      chk("step", {31'd0, bus.step}, {31'd0, m_step});
      chk("up", {31'd0, bus.up}, {31'd0, m_up});
      chk("count", {28'd0, bus.count}, {28'd0, m_count});
      chk("busy", {31'd0, bus.busy}, {31'd0, m_busy});
      if (bus.step === 1'b1) begin
        n_steps++;
        last_dir = bus.up;
        stimes.push_back(ncyc);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic u, input logic d, input int hold);
    bus.btn_up = u; bus.btn_dn = d;
    cyc(hold);
    bus.btn_up = 1'b0; bus.btn_dn = 1'b0;
    cyc(5);
  endtask

  int s0;
  int exp_off[6] = '{0, 12, 16, 20, 24, 28};

  initial begin
    bus.btn_up = 1'b1; bus.btn_dn = 1'b0; bus.mode_wrap = 1'b1;
    reset = 1'b1;
    cyc(3);
    chk("rst_step", {31'd0, bus.step}, 32'd0);
    chk("rst_up", {31'd0, bus.up}, 32'd0);
    chk("rst_count", {28'd0, bus.count}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;
    cyc(6);
    chk("held_thru_reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("held_thru_reset_steps", n_steps, 0);
    bus.btn_up = 1'b0;
    cyc(2);

    // Three short up presses.
    s0 = n_steps;
    repeat (3) begin
      press(1'b1, 1'b0, 3);
      chk("busy_between", {31'd0, bus.busy}, 32'd0);
    end
    chk("three_steps", n_steps - s0, 3);
    chk("count_3", {28'd0, bus.count}, 32'd3);
    chk("dir_up", {31'd0, last_dir}, 32'd1);

    // Round-robin ties after a fresh reset.
    reset = 1'b1; cyc(2); reset = 1'b0; cyc(2);
    press(1'b1, 1'b1, 3);
    chk("tie1_dir", {31'd0, last_dir}, 32'd1);
    chk("tie1_count", {28'd0, bus.count}, 32'd1);
    press(1'b1, 1'b1, 3);
    chk("tie2_dir", {31'd0, last_dir}, 32'd0);
    chk("tie2_count", {28'd0, bus.count}, 32'd0);

    // Limits at 15 and 0.
    press(1'b0, 1'b1, 3);
    chk("wrap_dn_to_15", {28'd0, bus.count}, 32'd15);
    bus.mode_wrap = 1'b0; s0 = n_steps;
    press(1'b1, 1'b0, 3);
    chk("sat_up_steps", n_steps - s0, 0);
    chk("sat_up_count", {28'd0, bus.count}, 32'd15);
    bus.mode_wrap = 1'b1; s0 = n_steps;
    press(1'b1, 1'b0, 3);
    chk("wrap_up_steps", n_steps - s0, 1);
    chk("wrap_up_count", {28'd0, bus.count}, 32'd0);
    bus.mode_wrap = 1'b0; s0 = n_steps;
    press(1'b0, 1'b1, 3);
    chk("sat_dn_steps", n_steps - s0, 0);
    chk("sat_dn_count", {28'd0, bus.count}, 32'd0);
    bus.mode_wrap = 1'b1;
    press(1'b0, 1'b1, 3);
    chk("wrap_dn_count", {28'd0, bus.count}, 32'd15);

    if (AR) begin
      repeat (5) press(1'b0, 1'b1, 3);
      chk("count_10", {28'd0, bus.count}, 32'd10);
      s0 = n_steps;
      stimes.delete();
      bus.btn_dn = 1'b1;
      cyc(30);
      bus.btn_dn = 1'b0;
      cyc(3);
      chk("repeat_steps", n_steps - s0, 6);
      chk("repeat_count", {28'd0, bus.count}, 32'd4);
      chk("repeat_nstamps", stimes.size(), 6);
      for (int k = 0; k < 6 && k < stimes.size(); k++)
        chk("repeat_spacing", stimes[k] - stimes[0], exp_off[k]);
      cyc(20);
      chk("no_step_after_release", n_steps - s0, 6);
    end else begin
      s0 = n_steps;
      bus.btn_up = 1'b1;
      cyc(10);
      bus.btn_dn = 1'b1;
      cyc(5);
      bus.btn_dn = 1'b0;
      cyc(25);
      bus.btn_up = 1'b0;
      cyc(5);
      chk("hold_one_step", n_steps - s0, 1);
      chk("hold_count", {28'd0, bus.count}, 32'd0);
      chk("hold_dir", {31'd0, last_dir}, 32'd1);
    end

    // Reset while a button is held mid-operation.
    bus.btn_up = 1'b1;
    cyc(16);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("midrst_step", {31'd0, bus.step}, 32'd0);
    chk("midrst_up", {31'd0, bus.up}, 32'd0);
    chk("midrst_count", {28'd0, bus.count}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    s0 = n_steps;
    cyc(20);
    chk("midrst_no_step", n_steps - s0, 0);
    chk("midrst_idle", {31'd0, bus.busy}, 32'd0);
    bus.btn_up = 1'b0;
    cyc(2);
    press(1'b1, 1'b0, 3);
    chk("repress_step", n_steps - s0, 1);
    chk("repress_count", {28'd0, bus.count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
